// File: rtl/filter_stream_rx.sv
// Sink/monitor for the 3x3 filter output stream: per-frame pixel count, checksum,
// min/max and geometry errors, reported with a one-cycle done strobe.
module filter_stream_rx #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CNT_W = 16,
    parameter int SUM_W = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_o,
    input  logic             valid_o,
    input  logic             frame_o,
    output logic             done,
    output logic [CNT_W-1:0] pix_count,
    output logic [SUM_W-1:0] checksum,
    output logic [WIDTH-1:0] pix_min,
    output logic [WIDTH-1:0] pix_max,
    output logic             err_short,
    output logic             err_long,
    output logic             err_orphan,
    output logic [15:0]      frame_count
);

    localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMG_W * IMG_H);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        REPORT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_acc;
    logic             w_report;

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_frame;

    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] r_sum;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_data  <= data_o;
            r_valid <= valid_o;
            r_frame <= frame_o;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Results are latched on the edge entering REPORT, so they are valid alongside done.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_acc       = 1'b0;
        w_report    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_frame) begin
                    w_state_nxt = ACTIVE;
                    w_load      = 1'b1;
                end
            end
            ACTIVE: begin
                if (r_frame) begin
                    w_acc = r_valid;
                end else begin
                    w_state_nxt = REPORT;
                    w_report    = 1'b1;
                end
            end
            REPORT: begin
                if (r_frame) begin
                    w_state_nxt = ACTIVE;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_sum <= '0;
            r_min <= '1;
            r_max <= '0;
        end else if (w_load) begin
            r_cnt <= r_valid ? CNT_W'(1) : '0;
            r_sum <= r_valid ? SUM_W'(r_data) : '0;
            r_min <= r_valid ? r_data : '1;
            r_max <= r_valid ? r_data : '0;
        end else if (w_acc) begin
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            r_sum <= r_sum + SUM_W'(r_data);
            if (r_data < r_min) r_min <= r_data;
            if (r_data > r_max) r_max <= r_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done        <= 1'b0;
            pix_count   <= '0;
            checksum    <= '0;
            pix_min     <= '1;
            pix_max     <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            frame_count <= '0;
        end else begin
            done <= w_report;
            if (w_report) begin
                pix_count   <= r_cnt;
                checksum    <= r_sum;
                pix_min     <= r_min;
                pix_max     <= r_max;
                err_short   <= (r_cnt < FRAME_PIX);
                err_long    <= (r_cnt > FRAME_PIX);
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                 err_orphan <= 1'b0;
        else if (r_valid && !r_frame) err_orphan <= 1'b1;
    end

endmodule

// File: tb/tb_filter_stream_rx.sv
// Directed, table-driven bench for filter_stream_rx with a 4x3 frame geometry.
module tb_filter_stream_rx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
    localparam int SUM_W = 24;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             frame_o;
    logic             done;
    logic [CNT_W-1:0] pix_count;
    logic [SUM_W-1:0] checksum;
    logic [WIDTH-1:0] pix_min;
    logic [WIDTH-1:0] pix_max;
    logic             err_short;
    logic             err_long;
    logic             err_orphan;
    logic [15:0]      frame_count;

    filter_stream_rx #(
        .WIDTH(WIDTH),
        .IMG_W(4),
        .IMG_H(3),
        .CNT_W(CNT_W),
        .SUM_W(SUM_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_o    (frame_o),
        .done       (done),
        .pix_count  (pix_count),
        .checksum   (checksum),
        .pix_min    (pix_min),
        .pix_max    (pix_max),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_orphan (err_orphan),
        .frame_count(frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int n;
        int base;
        int step;
        bit gaps;
        int cnt;
        int sum;
        int mn;
        int mx;
        bit es;
        bit el;
        int fc;
    } vec_t;

    vec_t tbl[5];
    int   n_chk;
    int   n_fail;
    int   n_done;
    int   exp_done;
    bit   exp_orphan;

    always @(posedge clock) if (done === 1'b1) n_done++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(pix_count), 0);
        chk("rst_sum", 32'(checksum), 0);
        chk("rst_min", 32'(pix_min), 255);
        chk("rst_max", 32'(pix_max), 0);
        chk("rst_short", 32'(err_short), 0);
        chk("rst_long", 32'(err_long), 0);
        chk("rst_orphan", 32'(err_orphan), 0);
        chk("rst_fc", 32'(frame_count), 0);
    endtask

    task automatic send_pixels(input int n, input int base, input int step, input bit gaps);
        if (n == 0) begin
            repeat (3) begin
                @(negedge clock);
                frame_o = 1'b1; valid_o = 1'b0; data_o = 8'h5A;
            end
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            frame_o = 1'b1; valid_o = 1'b1; data_o = 8'(base + i * step);
            if (gaps) begin
                @(negedge clock);
                valid_o = 1'b0; data_o = 8'hAA;
            end
        end
    endtask

    task automatic end_and_check(input vec_t v);
        @(negedge clock);
        frame_o = 1'b0; valid_o = 1'b0; data_o = 8'h00;
        @(posedge clock); #1;
        chk("done_early", 32'(done), 0);
        @(posedge clock); #1;
        chk("done_pulse", 32'(done), 1);
        chk("pix_count", 32'(pix_count), v.cnt);
        chk("checksum", 32'(checksum), v.sum);
        chk("pix_min", 32'(pix_min), v.mn);
        chk("pix_max", 32'(pix_max), v.mx);
        chk("err_short", 32'(err_short), 32'(v.es));
        chk("err_long", 32'(err_long), 32'(v.el));
        chk("err_orphan", 32'(err_orphan), 32'(exp_orphan));
        chk("frame_count", 32'(frame_count), v.fc);
        exp_done++;
        @(posedge clock); #1;
        chk("done_late", 32'(done), 0);
        chk("hold_count", 32'(pix_count), v.cnt);
    endtask

    initial begin
        vec_t v;
        n_chk = 0; n_fail = 0; n_done = 0; exp_done = 0; exp_orphan = 1'b0;
        //           n  base step gaps cnt sum  min  max  es el fc
        tbl[0] = '{12,   1,   1, 1'b0, 12,  78,   1,  12, 0, 0, 1};
        tbl[1] = '{12,   1,   1, 1'b1, 12,  78,   1,  12, 0, 0, 2};
        tbl[2] = '{10, 255,   0, 1'b0, 10, 2550, 255, 255, 1, 0, 3};
        tbl[3] = '{13,   1,   1, 1'b0, 13,  91,   1,  13, 0, 1, 4};
        tbl[4] = '{ 0,   0,   0, 1'b0,  0,   0, 255,   0, 1, 0, 5};

        reset = 1'b0; frame_o = 1'b0; valid_o = 1'b0; data_o = '0;
        repeat (2) @(negedge clock);
        check_reset_vals();
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int k = 0; k < 5; k++) begin
            send_pixels(tbl[k].n, tbl[k].base, tbl[k].step, tbl[k].gaps);
            end_and_check(tbl[k]);
        end

        // Orphan pixel between frames: sticky flag, no frame accounting.
        @(negedge clock); valid_o = 1'b1; data_o = 8'h33;
        @(negedge clock); valid_o = 1'b0;
        repeat (2) @(posedge clock); #1;
        chk("orphan_set", 32'(err_orphan), 1);
        chk("orphan_fc", 32'(frame_count), 5);
        chk("orphan_hold_sum", 32'(checksum), 0);
        exp_orphan = 1'b1;
        send_pixels(12, 1, 1, 1'b0);
        v = '{12, 1, 1, 1'b0, 12, 78, 1, 12, 0, 0, 6};
        end_and_check(v);

        // Back-to-back frames with a single low frame_o cycle.
        send_pixels(12, 1, 1, 1'b0);
        @(negedge clock); frame_o = 1'b0; valid_o = 1'b0;
        @(posedge clock); #1;
        chk("b2b_done_early", 32'(done), 0);
        @(negedge clock); frame_o = 1'b1; valid_o = 1'b1; data_o = 8'd2;
        @(posedge clock); #1;
        chk("b2b_done1", 32'(done), 1);
        chk("b2b_count1", 32'(pix_count), 12);
        chk("b2b_sum1", 32'(checksum), 78);
        chk("b2b_fc1", 32'(frame_count), 7);
        exp_done++;
        for (int i = 1; i < 12; i++) begin
            @(negedge clock); data_o = 8'(2 + i);
            if (i == 1) begin
                @(posedge clock); #1;
                chk("b2b_done1_end", 32'(done), 0);
            end
        end
        v = '{12, 2, 1, 1'b0, 12, 90, 2, 13, 0, 0, 8};
        end_and_check(v);

        // Reset after 5 pixels discards the partial frame.
        send_pixels(5, 7, 1, 1'b0);
        @(negedge clock);
        reset = 1'b0; frame_o = 1'b0; valid_o = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clock); reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_no_done", 32'(n_done), 32'(exp_done));
        exp_orphan = 1'b0;
        send_pixels(12, 1, 1, 1'b0);
        v = '{12, 1, 1, 1'b0, 12, 78, 1, 12, 0, 0, 1};
        end_and_check(v);

        repeat (3) @(posedge clock); #1;
        chk("done_total", 32'(n_done), 32'(exp_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
